// File: rtl/exu_lsu_if.sv
// exu_lsu_if: bundle for the load/store unit.
//   req_*      EXU control -> LSU access request (req_ready back)
//   bus_req_*  LSU -> memory bus request (bus_req_ready back)
//   bus_rsp_*  memory bus -> LSU response
//   wb_*       LSU -> GPR writeback pulse
//   done/exc_* LSU -> EXU retire / exception pulse
// master: the EXU/bus environment around the LSU.
// slave:  the LSU itself.
interface exu_lsu_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [AW-1:0]     req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [AW-1:0]     bus_req_addr;
  logic              bus_req_wen;
  logic [XLEN/8-1:0] bus_req_wstrb;
  logic [XLEN-1:0]   bus_req_wdata;
  logic              bus_rsp_valid;
  logic              bus_rsp_err;
  logic [XLEN-1:0]   bus_rsp_rdata;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              done;
  logic              exc_valid;
  logic [3:0]        exc_cause;
  logic [AW-1:0]     exc_addr;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wstrb, bus_req_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rsp_err, bus_rsp_rdata,
    input  wb_valid, wb_rd, wb_data, done, exc_valid, exc_cause, exc_addr
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wstrb, bus_req_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_err, bus_rsp_rdata,
    output wb_valid, wb_rd, wb_data, done, exc_valid, exc_cause, exc_addr
  );
endinterface

// File: rtl/exu_lsu.sv
// exu_lsu: load/store unit behind the EXU ALU. Accepts one access at a time,
// issues one word-aligned bus transaction and retires it with a GPR writeback
// (loads) or an exception pulse (illegal, misaligned, bus fault).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   io   exu_lsu_if.slave: request, bus request/response, writeback, retire
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; also the done cycle of a bus access
// REQ   | bus request presented, waiting for bus_req_ready
// RSP   | request accepted by the bus, waiting for bus_rsp_valid
// FIN   | rejected access; done/exc pulse is visible this cycle
module exu_lsu #(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic     clk,
  input  logic     rst,
  exu_lsu_if.slave io
);
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, RSP, FIN} state_t;

  state_t        state;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic [4:0]    rd_q;
  logic [AW-1:0] addr_q;

  logic            legal;
  logic            aligned;
  logic [3:0]      rej_cause;
  logic [NB-1:0]   wstrb_c;
  logic [XLEN-1:0] wdata_c;

  // decode of the incoming request, used only in the accept cycle
  always_comb begin
    if (io.req_is_store)
      legal = (io.req_funct3[2] == 1'b0) && (io.req_funct3[1:0] != 2'b11);
    else
      legal = io.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    case (io.req_funct3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~io.req_addr[0];
      2'd2:    aligned = (io.req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase

    if (!legal)            rej_cause = 4'd2;
    else if (io.req_is_store) rej_cause = 4'd6;
    else                   rej_cause = 4'd4;

    // store data is replicated across lanes so the strobe alone selects bytes
    case (io.req_funct3[1:0])
      2'd0: begin
        wstrb_c = 4'b0001 << io.req_addr[1:0];
        wdata_c = {NB{io.req_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_c = 4'b0011 << io.req_addr[1:0];
        wdata_c = {(NB/2){io.req_wdata[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = io.req_wdata;
      end
    endcase
  end

  logic [XLEN-1:0] rsp_sh;
  logic [XLEN-1:0] ld_val;

  // halfword accesses are aligned, so shifting by the byte lane also
  // selects the correct half
  always_comb begin
    rsp_sh = io.bus_rsp_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'd0:    ld_val = {{(XLEN-8){rsp_sh[7]}}, rsp_sh[7:0]};
      3'd1:    ld_val = {{(XLEN-16){rsp_sh[15]}}, rsp_sh[15:0]};
      3'd4:    ld_val = {{(XLEN-8){1'b0}}, rsp_sh[7:0]};
      3'd5:    ld_val = {{(XLEN-16){1'b0}}, rsp_sh[15:0]};
      default: ld_val = io.bus_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      st_q             <= 1'b0;
      f3_q             <= 3'd0;
      lane_q           <= 2'd0;
      rd_q             <= 5'd0;
      addr_q           <= '0;
      io.req_ready     <= 1'b1;
      io.bus_req_valid <= 1'b0;
      io.bus_req_addr  <= '0;
      io.bus_req_wen   <= 1'b0;
      io.bus_req_wstrb <= '0;
      io.bus_req_wdata <= '0;
      io.wb_valid      <= 1'b0;
      io.wb_rd         <= 5'd0;
      io.wb_data       <= '0;
      io.done          <= 1'b0;
      io.exc_valid     <= 1'b0;
      io.exc_cause     <= 4'd0;
      io.exc_addr      <= '0;
    end else begin
      // retire outputs are single-cycle pulses and read as zero otherwise
      io.wb_valid  <= 1'b0;
      io.wb_rd     <= 5'd0;
      io.wb_data   <= '0;
      io.done      <= 1'b0;
      io.exc_valid <= 1'b0;
      io.exc_cause <= 4'd0;
      io.exc_addr  <= '0;

      case (state)
        IDLE: begin
          if (!io.req_ready) begin
            // done cycle of a bus access; open for the next request
            io.req_ready <= 1'b1;
          end else if (io.req_valid) begin
            io.req_ready <= 1'b0;
            st_q         <= io.req_is_store;
            f3_q         <= io.req_funct3;
            lane_q       <= io.req_addr[1:0];
            rd_q         <= io.req_rd;
            addr_q       <= io.req_addr;
            if (!legal || !aligned) begin
              state        <= FIN;
              io.done      <= 1'b1;
              io.exc_valid <= 1'b1;
              io.exc_cause <= rej_cause;
              io.exc_addr  <= io.req_addr;
            end else begin
              state            <= REQ;
              io.bus_req_valid <= 1'b1;
              io.bus_req_addr  <= {io.req_addr[AW-1:2], 2'b00};
              io.bus_req_wen   <= io.req_is_store;
              io.bus_req_wstrb <= io.req_is_store ? wstrb_c : '0;
              io.bus_req_wdata <= io.req_is_store ? wdata_c : '0;
            end
          end
        end

        FIN: begin
          state        <= IDLE;
          io.req_ready <= 1'b1;
        end

        REQ: begin
          if (io.bus_req_ready) begin
            state            <= RSP;
            io.bus_req_valid <= 1'b0;
            io.bus_req_addr  <= '0;
            io.bus_req_wen   <= 1'b0;
            io.bus_req_wstrb <= '0;
            io.bus_req_wdata <= '0;
          end
        end

        RSP: begin
          if (io.bus_rsp_valid) begin
            // req_ready stays low through the done cycle spent in IDLE
            state   <= IDLE;
            io.done <= 1'b1;
            if (io.bus_rsp_err) begin
              io.exc_valid <= 1'b1;
              io.exc_cause <= st_q ? 4'd7 : 4'd5;
              io.exc_addr  <= addr_q;
            end else if (!st_q && (rd_q != 5'd0)) begin
              io.wb_valid <= 1'b1;
              io.wb_rd    <= rd_q;
              io.wb_data  <= ld_val;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_lsu.sv
module tb_exu_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exu_lsu_if #(.XLEN(32), .AW(32)) lsu_if ();
  exu_lsu #(.XLEN(32), .AW(32)) dut (.clk(clk), .rst(rst), .io(lsu_if.slave));

  typedef struct {
    bit          exc;
    logic [3:0]  cause;
    logic [31:0] eaddr;
    bit          wb;
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    bit          wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } busreq_t;

  done_t   done_q[$];
  busreq_t bus_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event/timeout 1 want 0", name);
  endtask

  // reference model: what the access should do, from the ISA rules
  function automatic void model(input bit st, input bit [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdata, input bit err,
                                input logic [4:0] rd, output done_t d, output bit go,
                                output busreq_t b);
    int unsigned size;
    int unsigned off;
    logic [31:0] v;
    bit legal;
    d = '{default: 0};
    b = '{default: 0};
    go = 1'b0;
    legal = st ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    size = 1 << (f3 % 4);
    off  = a % 4;
    if (!legal) begin
      d.exc = 1; d.cause = 4'd2; d.eaddr = a;
      return;
    end
    if ((a % size) != 0) begin
      d.exc = 1; d.cause = st ? 4'd6 : 4'd4; d.eaddr = a;
      return;
    end
    go = 1'b1;
    b.addr = a - off;
    b.wen  = st;
    if (st) begin
      b.strb = 4'(((1 << size) - 1) << off);
      if (size == 1)      b.wdata = wd[7:0] * 32'h01010101;
      else if (size == 2) b.wdata = wd[15:0] * 32'h00010001;
      else                b.wdata = wd;
    end
    if (err) begin
      d.exc = 1; d.cause = st ? 4'd7 : 4'd5; d.eaddr = a;
      return;
    end
    if (st || rd == 0) return;
    v = rdata >> (8 * off);
    if (size == 1) begin
      v = v % 32'd256;
      if (f3 == 0 && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2) begin
      v = v % 32'd65536;
      if (f3 == 1 && v >= 32'd32768) v = v - 32'd65536;
    end
    d.wb = 1; d.rd = rd; d.data = v;
  endfunction

  // monitor: retire scoreboard plus bus request checker
  done_t   md;
  busreq_t held;
  bit done_prev = 0;
  bit pend = 0;

  always @(negedge clk) begin
    if (rst) begin
      done_prev = 0;
      pend = 0;
    end else begin
      if (lsu_if.done) begin
        check("done_req_ready_low", {31'd0, lsu_if.req_ready}, 32'd0);
        if (done_prev) fail("done_not_single_cycle");
        if (done_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          md = done_q.pop_front();
          check("latency", cyc, md.due);
          check("exc_valid", {31'd0, lsu_if.exc_valid}, {31'd0, md.exc});
          check("exc_cause", {28'd0, lsu_if.exc_cause}, md.exc ? {28'd0, md.cause} : 32'd0);
          check("exc_addr", lsu_if.exc_addr, md.exc ? md.eaddr : 32'd0);
          check("wb_valid", {31'd0, lsu_if.wb_valid}, {31'd0, md.wb});
          check("wb_data", lsu_if.wb_data, md.wb ? md.data : 32'd0);
          if (md.wb) check("wb_rd", {27'd0, lsu_if.wb_rd}, {27'd0, md.rd});
        end
      end else begin
        check("quiet_outputs",
              {27'd0, lsu_if.wb_valid, lsu_if.exc_valid, |lsu_if.wb_data,
               |lsu_if.exc_cause, |lsu_if.exc_addr}, 32'd0);
      end
      if (done_prev) check("req_ready_after_done", {31'd0, lsu_if.req_ready}, 32'd1);
      done_prev = lsu_if.done;

      if (lsu_if.bus_req_valid) begin
        if (!pend) begin
          if (bus_q.size() == 0) begin
            fail("unexpected_bus_req");
            held = '{default: 0};
            held.addr = lsu_if.bus_req_addr;
            held.wen = lsu_if.bus_req_wen;
            held.strb = lsu_if.bus_req_wstrb;
            held.wdata = lsu_if.bus_req_wdata;
          end else begin
            held = bus_q.pop_front();
          end
        end
        check("bus_addr", lsu_if.bus_req_addr, held.addr);
        check("bus_wen", {31'd0, lsu_if.bus_req_wen}, {31'd0, held.wen});
        check("bus_wstrb", {28'd0, lsu_if.bus_req_wstrb}, {28'd0, held.strb});
        if (held.wen) check("bus_wdata", lsu_if.bus_req_wdata, held.wdata);
        pend = !lsu_if.bus_req_ready;
      end else if (pend) begin
        fail("bus_req_dropped");
        pend = 0;
      end
    end
  end

  task automatic access(input bit st, input bit [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input bit err,
                        input logic [4:0] rd, input int rdy_dly, input int rsp_dly,
                        input bit rst_mid);
    done_t d;
    busreq_t b;
    bit go;
    int n;
    model(st, f3, a, wd, rdata, err, rd, d, go, b);

    n = 0;
    @(negedge clk);
    while (!lsu_if.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!lsu_if.req_ready) begin
      fail("req_ready_timeout");
      return;
    end
    lsu_if.req_valid    = 1'b1;
    lsu_if.req_is_store = st;
    lsu_if.req_funct3   = f3;
    lsu_if.req_addr     = a;
    lsu_if.req_wdata    = wd;
    lsu_if.req_rd       = rd;
    @(posedge clk);
    #1;
    lsu_if.req_valid = 1'b0;
    lsu_if.req_addr  = $urandom;
    lsu_if.req_wdata = $urandom;
    d.due = go ? cyc + 2 + rdy_dly + rsp_dly : cyc;
    if (!rst_mid) done_q.push_back(d);
    if (go) bus_q.push_back(b);

    if (go) begin
      lsu_if.bus_req_ready = 1'b0;
      if (rdy_dly > 0) begin
        // a response arriving before the request handshake must be dropped
        lsu_if.bus_rsp_valid = 1'b1;
        lsu_if.bus_rsp_err   = 1'b1;
        repeat (rdy_dly) @(posedge clk);
        #1;
        lsu_if.bus_rsp_valid = 1'b0;
        lsu_if.bus_rsp_err   = 1'b0;
      end
      lsu_if.bus_req_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!lsu_if.bus_req_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!lsu_if.bus_req_valid) fail("bus_req_timeout");
      @(posedge clk);
      #1;
      lsu_if.bus_req_ready = 1'b0;

      if (rst_mid) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_done", {31'd0, lsu_if.done}, 32'd0);
        check("rst_wb_valid", {31'd0, lsu_if.wb_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lsu_if.bus_rsp_valid = 1'b1;
        lsu_if.bus_rsp_rdata = rdata;
        @(negedge clk);
        check("req_ready_after_rst", {31'd0, lsu_if.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        lsu_if.bus_rsp_valid = 1'b0;
        repeat (4) @(negedge clk);
        return;
      end

      repeat (rsp_dly) @(posedge clk);
      if (rsp_dly > 0) #1;
      lsu_if.bus_rsp_valid = 1'b1;
      lsu_if.bus_rsp_err   = err;
      lsu_if.bus_rsp_rdata = rdata;
      @(posedge clk);
      #1;
      lsu_if.bus_rsp_valid = 1'b0;
      lsu_if.bus_rsp_err   = 1'b0;
      lsu_if.bus_rsp_rdata = $urandom;
    end

    n = 0;
    while (done_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done_q.size() != 0) begin
      fail("done_timeout");
      done_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    lsu_if.req_valid     = 1'b0;
    lsu_if.req_is_store  = 1'b0;
    lsu_if.req_funct3    = 3'd0;
    lsu_if.req_addr      = '0;
    lsu_if.req_wdata     = '0;
    lsu_if.req_rd        = 5'd0;
    lsu_if.bus_req_ready = 1'b0;
    lsu_if.bus_rsp_valid = 1'b0;
    lsu_if.bus_rsp_err   = 1'b0;
    lsu_if.bus_rsp_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", {31'd0, lsu_if.req_ready}, 32'd1);
    check("reset_bus_req_valid", {31'd0, lsu_if.bus_req_valid}, 32'd0);
    check("reset_done", {31'd0, lsu_if.done}, 32'd0);
    check("reset_wb", {30'd0, lsu_if.wb_valid, lsu_if.exc_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", {31'd0, lsu_if.req_ready}, 32'd1);

    access(0, 3'd2, 32'h100, 32'h0,      32'hDEADBEEF, 0, 5'd5, 0, 0, 0);
    access(0, 3'd0, 32'h103, 32'h0,      32'h80FF0000, 0, 5'd7, 0, 0, 0);
    access(0, 3'd4, 32'h103, 32'h0,      32'h80FF0000, 0, 5'd8, 1, 0, 0);
    access(0, 3'd5, 32'h102, 32'h0,      32'h80FF0000, 0, 5'd9, 0, 2, 0);
    access(0, 3'd1, 32'h102, 32'h0,      32'h80FF0000, 0, 5'd10, 0, 0, 0);
    access(1, 3'd1, 32'h206, 32'h1234ABCD, 32'h0,      0, 5'd3, 0, 0, 0);
    access(1, 3'd0, 32'h201, 32'h000000A5, 32'h0,      0, 5'd0, 0, 1, 0);
    access(0, 3'd2, 32'h101, 32'h0,      32'h0,        0, 5'd4, 0, 0, 0);
    access(1, 3'd3, 32'h200, 32'h0,      32'h0,        0, 5'd0, 0, 0, 0);
    access(1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0,      1, 5'd0, 4, 0, 0);
    access(0, 3'd0, 32'h104, 32'h0,      32'h1234567F, 0, 5'd0, 0, 0, 0);
    access(0, 3'd2, 32'h400, 32'h0,      32'h55AA55AA, 0, 5'd9, 1, 3, 1);
    access(0, 3'd2, 32'h404, 32'h0,      32'h01020304, 0, 5'd11, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom & 32'hFFF,
             $urandom, $urandom, ($urandom_range(0, 5) == 0), 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    repeat (3) @(negedge clk);
    check("done_queue_drained", done_q.size(), 32'd0);
    check("bus_queue_drained", bus_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
